// File: rtl/ucie_ig_pattern_buf.sv
// Ingress pattern buffer: stores CSR-written words in a flop array and
// replays a start..stop window as a valid/ready stream, once or looped.
//
// state | meaning
// IDLE  | no replay since reset/clr, o_tx_valid low
// RUN   | replaying window, o_tx_valid high unless held
// DONE  | requested passes finished, rptr parked on stop entry
module ucie_ig_pattern_buf #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 32,
    parameter int PWIDTH = 5,
    parameter int LWIDTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wdata_clr,
    input  logic              i_wdata_en,
    input  logic              i_wdata_upd,
    input  logic [DWIDTH-1:0] i_wdata,
    input  logic              i_wdata_hold,
    input  logic              i_load_ptr,
    input  logic [PWIDTH-1:0] i_start_ptr,
    input  logic [PWIDTH-1:0] i_stop_ptr,
    input  logic              i_loop_mode,
    input  logic [LWIDTH-1:0] i_num_loops,
    output logic [DWIDTH-1:0] o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_write_done,
    output logic              o_overflow
);

    localparam logic [PWIDTH:0] DEPTH_C = (PWIDTH+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [PWIDTH-1:0] wptr;
    logic [PWIDTH:0]   count;
    logic [PWIDTH-1:0] rptr, rptr_nx;
    logic [LWIDTH-1:0] loop_cnt, loop_cnt_nx;
    logic [LWIDTH:0]   loop_inc;
    state_t            state, state_nx;
    logic              upd_q, load_q, wr_pend;
    logic              upd_rise, load_rise, xfer;

    assign upd_rise   = i_wdata_upd & ~upd_q;
    assign load_rise  = i_load_ptr & ~load_q;
    assign o_tx_valid = (state == RUN) && !i_wdata_hold;
    assign xfer       = o_tx_valid && i_tx_ready;
    assign o_tx_data  = mem[rptr];
    assign o_empty    = (count == '0);
    assign o_full     = (count == DEPTH_C);
    assign loop_inc   = {1'b0, loop_cnt} + {{LWIDTH{1'b0}}, 1'b1};

    // Edge detectors keep sampling through clr so a held level cannot retrigger.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            upd_q  <= 1'b0;
            load_q <= 1'b0;
        end else begin
            upd_q  <= i_wdata_upd;
            load_q <= i_load_ptr;
        end
    end

    // Write side: store on enabled update edge, flag overflow when full.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr         <= '0;
            count        <= '0;
            o_overflow   <= 1'b0;
            o_write_done <= 1'b0;
            wr_pend      <= 1'b0;
        end else if (i_wdata_clr) begin
            wptr         <= '0;
            count        <= '0;
            o_overflow   <= 1'b0;
            o_write_done <= 1'b0;
            wr_pend      <= 1'b0;
        end else if (upd_rise && i_wdata_en) begin
            o_write_done <= 1'b0;
            wr_pend      <= 1'b1;
            if (count < DEPTH_C) begin
                mem[wptr] <= i_wdata;
                wptr      <= wptr + PWIDTH'(1);
                count     <= count + (PWIDTH+1)'(1);
            end else begin
                o_overflow <= 1'b1;
            end
        end else if (wr_pend) begin
            o_write_done <= 1'b1;
            wr_pend      <= 1'b0;
        end
    end

    // Replay state, read pointer and pass counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            rptr     <= '0;
            loop_cnt <= '0;
        end else if (i_wdata_clr) begin
            state    <= IDLE;
            rptr     <= '0;
            loop_cnt <= '0;
        end else begin
            state    <= state_nx;
            rptr     <= rptr_nx;
            loop_cnt <= loop_cnt_nx;
        end
    end

    // Next replay state: a load edge restarts ahead of any same-cycle transfer.
    always_comb begin
        state_nx    = state;
        rptr_nx     = rptr;
        loop_cnt_nx = loop_cnt;
        if (load_rise) begin
            state_nx    = RUN;
            rptr_nx     = i_start_ptr;
            loop_cnt_nx = '0;
        end else if (xfer) begin
            if (rptr != i_stop_ptr) begin
                rptr_nx = rptr + PWIDTH'(1);
            end else if (i_loop_mode && (i_num_loops == '0)) begin
                rptr_nx = i_start_ptr;
            end else if (i_loop_mode && (loop_inc < {1'b0, i_num_loops})) begin
                rptr_nx     = i_start_ptr;
                loop_cnt_nx = loop_inc[LWIDTH-1:0];
            end else begin
                state_nx = DONE;
            end
        end
    end

endmodule

// File: tb/tb_ucie_ig_pattern_buf.sv
// Randomized bench for ucie_ig_pattern_buf with a queue-based replay model.
module tb_ucie_ig_pattern_buf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0, wen = 1'b0, upd = 1'b0, hold = 1'b0, load = 1'b0;
    logic [31:0] wdata = '0;
    logic [4:0]  start_p = '0, stop_p = '0;
    logic        loop_mode = 1'b0;
    logic [3:0]  num_loops = '0;
    logic        ready = 1'b0;
    logic [31:0] tx_data;
    logic        tx_valid, empty, full, write_done, overflow;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] mem_m [32];
    int          cnt_m = 0;
    logic        ovf_m = 1'b0;
    int          exp_q [$];

    always #5 clk = ~clk;

    ucie_ig_pattern_buf dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wdata_clr(clr), .i_wdata_en(wen),
        .i_wdata_upd(upd), .i_wdata(wdata), .i_wdata_hold(hold),
        .i_load_ptr(load), .i_start_ptr(start_p), .i_stop_ptr(stop_p),
        .i_loop_mode(loop_mode), .i_num_loops(num_loops),
        .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(ready),
        .o_empty(empty), .o_full(full), .o_write_done(write_done),
        .o_overflow(overflow)
    );

    task automatic model_write(input logic [31:0] d, input bit en);
        if (en) begin
            if (cnt_m < 32) begin
                mem_m[cnt_m] = d;
                cnt_m++;
            end else begin
                ovf_m = 1'b1;
            end
        end
    endtask

    task automatic write_word(input logic [31:0] d, input bit en);
        @(negedge clk);
        wdata = d; wen = en; upd = 1'b1;
        @(negedge clk);
        upd = 1'b0;
        model_write(d, en);
    endtask

    task automatic do_clr();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        cnt_m = 0; ovf_m = 1'b0;
    endtask

    task automatic check_status(input string name);
        #1;
        vectors++;
        if (empty !== (cnt_m == 0) || full !== (cnt_m == 32) || overflow !== ovf_m) begin
            errors++;
            $display("FAIL %s: empty/full/ovf got %b%b%b want %b%b%b", name,
                     empty, full, overflow, cnt_m == 0, cnt_m == 32, ovf_m);
        end
    endtask

    task automatic launch(input int s, input int e, input bit lm, input int nl);
        int passes;
        int idx;
        @(negedge clk);
        start_p = 5'(s); stop_p = 5'(e); loop_mode = lm; num_loops = 4'(nl);
        ready = 1'b1; hold = 1'b0; load = 1'b1;
        passes = (!lm) ? 1 : ((nl == 0) ? 3 : nl);
        exp_q.delete();
        for (int p = 0; p < passes; p++) begin
            idx = s;
            forever begin
                exp_q.push_back(idx);
                if (idx == e) break;
                idx = (idx + 1) % 32;
            end
        end
    endtask

    task automatic stream(input int limit, input bit rnd);
        int n = 0;
        int cyc = 0;
        while (exp_q.size() > 0 && n < limit && cyc < 2000) begin
            @(negedge clk);
            load = 1'b0;
            cyc++;
            if (rnd) begin
                ready = 1'($urandom_range(0, 1));
                hold  = ($urandom_range(0, 3) == 0);
            end else begin
                ready = 1'b1; hold = 1'b0;
            end
            #1;
            vectors++;
            if (tx_valid !== !hold) begin
                errors++;
                $display("FAIL stream_valid: got %b want %b (left %0d)", tx_valid, !hold, exp_q.size());
            end
            if (tx_valid === 1'b1 && tx_data !== mem_m[exp_q[0]]) begin
                errors++;
                $display("FAIL stream_data: got %h want %h (entry %0d)", tx_data, mem_m[exp_q[0]], exp_q[0]);
            end
            if (tx_valid === 1'b1 && ready) begin
                void'(exp_q.pop_front());
                n++;
            end
        end
        if (cyc >= 2000) begin
            errors++;
            $display("FAIL stream_timeout: %0d words left, want 0", exp_q.size());
        end
    endtask

    task automatic check_valid(input string name, input logic want);
        @(negedge clk);
        ready = 1'b1; hold = 1'b0;
        #1;
        vectors++;
        if (tx_valid !== want) begin
            errors++;
            $display("FAIL %s: valid got %b want %b", name, tx_valid, want);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        #3;
        vectors++;
        if (empty !== 1'b1 || full !== 1'b0 || write_done !== 1'b0 || overflow !== 1'b0 ||
            tx_valid !== 1'b0 || tx_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: e%b f%b wd%b ov%b v%b d%h want e1 f0 wd0 ov0 v0 d0",
                     empty, full, write_done, overflow, tx_valid, tx_data);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d = 32'hA0 + 32'(i);
            @(negedge clk); wdata = d; wen = 1'b1; upd = 1'b1;
            @(negedge clk); upd = 1'b0;
            model_write(d, 1'b1);
            #1;
            vectors++;
            if (write_done !== 1'b0) begin
                errors++;
                $display("FAIL write_done_edge: got %b want 0", write_done);
            end
            @(negedge clk); #1;
            vectors++;
            if (write_done !== 1'b1) begin
                errors++;
                $display("FAIL write_done_after: got %b want 1", write_done);
            end
        end
        check_status("three_words");
    endtask

    task automatic test_full();
        do_clr();
        for (int i = 0; i < 33; i++) begin
            write_word($urandom, 1'b1);
            check_status("fill");
        end
        write_word($urandom, 1'b1);
        check_status("overflow_sticky");
        do_clr();
        check_status("after_clr");
        vectors++;
        if (write_done !== 1'b0) begin
            errors++;
            $display("FAIL clr_write_done: got %b want 0", write_done);
        end
        write_word($urandom, 1'b1);
        write_word(32'hDEADBEEF, 1'b0);
        vectors++;
        if (write_done !== 1'b1) begin
            errors++;
            $display("FAIL en0_write_done: got %b want 1", write_done);
        end
        for (int i = 0; i < 3; i++) write_word($urandom, 1'b1);
        check_status("refill");
    endtask

    task automatic test_single_pass();
        launch(1, 3, 1'b0, 0);
        stream(100, 1'b0);
        check_valid("single_done", 1'b0);
    endtask

    task automatic test_loop();
        launch(30, 1, 1'b1, 2);
        stream(100, 1'b0);
        check_valid("loop2_done", 1'b0);
        launch(7, 7, 1'b1, 3);
        stream(100, 1'b1);
        check_valid("one_word_done", 1'b0);
    endtask

    task automatic test_infinite();
        launch(30, 1, 1'b1, 0);
        stream(100, 1'b1);
        @(negedge clk); ready = 1'b0; hold = 1'b0; #1;
        vectors++;
        if (tx_valid !== 1'b1 || tx_data !== mem_m[30]) begin
            errors++;
            $display("FAIL infinite_wrap: valid %b data %h want 1 %h", tx_valid, tx_data, mem_m[30]);
        end
        do_clr();
        check_valid("clr_stops", 1'b0);
    endtask

    task automatic test_ready_hold();
        for (int r = 0; r < 4; r++) begin
            launch($urandom_range(0, 31), $urandom_range(0, 31), 1'($urandom_range(0, 1)),
                   $urandom_range(1, 3));
            stream(1000, 1'b1);
            check_valid("random_done", 1'b0);
        end
    endtask

    task automatic test_restart();
        launch(2, 9, 1'b0, 0);
        stream(4, 1'b0);
        launch(20, 22, 1'b0, 0);
        stream(100, 1'b1);
        check_valid("restart_done", 1'b0);
    endtask

    task automatic test_async_reset();
        launch(10, 20, 1'b0, 0);
        stream(3, 1'b0);
        @(negedge clk); ready = 1'b1; hold = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_valid: got %b want 0", tx_valid);
        end
        for (int i = 0; i < 32; i++) mem_m[i] = '0;
        cnt_m = 0; ovf_m = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (tx_valid !== 1'b0 || tx_data !== 32'h0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_idle: v%b d%h e%b want v0 d0 e1", tx_valid, tx_data, empty);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem_m[i] = '0;
        test_reset();
        test_full();
        test_single_pass();
        test_loop();
        test_infinite();
        test_ready_hold();
        test_restart();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
